// File: rtl/memory_pkg.sv
// ----------------------------------------------------------------------------
// memory_pkg : access-width / result-source encodings and LSU state type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package memory_pkg;

  localparam logic [2:0] WIDTH_W  = 3'b000;
  localparam logic [2:0] WIDTH_HS = 3'b001;
  localparam logic [2:0] WIDTH_BS = 3'b010;
  localparam logic [2:0] WIDTH_HU = 3'b011;
  localparam logic [2:0] WIDTH_BU = 3'b100;

  localparam logic [2:0] RES_ALU = 3'b000;
  localparam logic [2:0] RES_MEM = 3'b001;
  localparam logic [2:0] RES_PCT = 3'b010;
  localparam logic [2:0] RES_PC4 = 3'b011;
  localparam logic [2:0] RES_IMM = 3'b100;
  localparam logic [2:0] RES_CSR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_target;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] csr_result;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic [2:0]  width_src;
    logic [2:0]  result_src;
    logic        mem_write;
    logic        reg_write;
    logic        csr_we;
  } m_payload_t;

  function automatic logic is_half(input logic [2:0] width);
    return (width == WIDTH_HS) || (width == WIDTH_HU);
  endfunction

  function automatic logic is_byte(input logic [2:0] width);
    return (width == WIDTH_BS) || (width == WIDTH_BU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flop.sv
// ----------------------------------------------------------------------------
// flop : enable/clear pipeline register with configurable reset value
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module flop #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear outranks enable so a flush lands even while the stage is stalled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend : picks the addressed lane of a read word and sign/zero extends
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_extend
  import memory_pkg::*;
(
  input  logic [2:0]  width_src,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] lane;

  // A half at offset 3 only has byte lane 3 left after the shift.
  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (width_src)
      WIDTH_HS: data = {{16{lane[15]}}, lane[15:0]};
      WIDTH_BS: data = {{24{lane[7]}}, lane[7:0]};
      WIDTH_HU: data = {16'h0000, lane[15:0]};
      WIDTH_BU: data = {24'h000000, lane[7:0]};
      default:  data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage : E->M pipeline register plus load/store unit on the dmem bus.
// Optional misaligned-access trap: define MEM_MISALIGN_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module memory_stage
  import memory_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [31:0] RESET_PC_PLUS4 = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_e_i,
  input  logic [31:0]           instr_e_i,
  input  logic [31:0]           alu_result_e_i,
  input  logic [31:0]           write_data_e_i,
  input  logic [31:0]           pc_target_e_i,
  input  logic [31:0]           pc_plus4_e_i,
  input  logic [31:0]           imm_ext_e_i,
  input  logic [31:0]           csr_result_e_i,
  input  logic [11:0]           csr_addr_e_i,
  input  logic [4:0]            rd_e_i,
  input  logic [2:0]            width_src_e_i,
  input  logic [2:0]            result_src_e_i,
  input  logic                  mem_write_e_i,
  input  logic                  reg_write_e_i,
  input  logic                  csr_we_e_i,
  input  logic                  stall_m_i,
  input  logic                  flush_m_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  mem_stall_o,
  output logic                  misaligned_m_o,
  output logic [31:0]           forward_data_m_o,
  output logic [31:0]           load_data_m_o,
  output logic                  valid_m_o,
  output logic [31:0]           instr_m_o,
  output logic [31:0]           alu_result_m_o,
  output logic [31:0]           pc_target_m_o,
  output logic [31:0]           pc_plus4_m_o,
  output logic [31:0]           imm_ext_m_o,
  output logic [31:0]           csr_result_m_o,
  output logic [11:0]           csr_addr_m_o,
  output logic [4:0]            rd_m_o,
  output logic [2:0]            result_src_m_o,
  output logic                  reg_write_m_o,
  output logic                  csr_we_m_o
);

  localparam m_payload_t PIPE_RST = '{pc_plus4: RESET_PC_PLUS4, default: '0};

  m_payload_t  pipe_d;
  m_payload_t  pipe_q;
  lsu_state_t  state;
  lsu_state_t  state_nxt;
  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        advance;
  logic [1:0]  offset;
  logic [31:0] word_addr;
  logic [31:0] ext_data;
  logic [31:0] load_q;

  always_comb begin
    pipe_d            = '0;
    pipe_d.valid      = valid_e_i;
    pipe_d.instr      = instr_e_i;
    pipe_d.alu_result = alu_result_e_i;
    pipe_d.write_data = write_data_e_i;
    pipe_d.pc_target  = pc_target_e_i;
    pipe_d.pc_plus4   = pc_plus4_e_i;
    pipe_d.imm_ext    = imm_ext_e_i;
    pipe_d.csr_result = csr_result_e_i;
    pipe_d.csr_addr   = csr_addr_e_i;
    pipe_d.rd         = rd_e_i;
    pipe_d.width_src  = width_src_e_i;
    pipe_d.result_src = result_src_e_i;
    pipe_d.mem_write  = mem_write_e_i;
    pipe_d.reg_write  = reg_write_e_i;
    pipe_d.csr_we     = csr_we_e_i;
  end

  flop #(
    .WIDTH   ($bits(m_payload_t)),
    .RST_VAL (PIPE_RST)
  ) u_pipe (
    .clk   (clk_i),
    .reset (reset_i),
    .en    (advance),
    .clr   (flush_m_i),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign offset    = pipe_q.alu_result[1:0];
  assign word_addr = {pipe_q.alu_result[31:2], 2'b00};
  assign mem_op    = pipe_q.valid & (pipe_q.mem_write | (pipe_q.result_src == RES_MEM));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = mem_op &
                      ((is_half(pipe_q.width_src) & offset[0]) |
                       (~is_half(pipe_q.width_src) & ~is_byte(pipe_q.width_src) &
                        (offset != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign issue       = mem_op & ~misaligned;
  assign mem_stall_o = (mem_op & (state != ST_DONE)) | (state == ST_DRAIN);
  assign advance     = ~(stall_m_i | mem_stall_o);

  assign dmem_req_o  = issue & ((state == ST_IDLE) | (state == ST_REQ));
  assign dmem_we_o   = pipe_q.mem_write;
  assign dmem_addr_o = word_addr[ADDR_WIDTH-1:0];

  always_comb begin
    dmem_be_o    = 4'hF;
    dmem_wdata_o = pipe_q.write_data;
    if (is_byte(pipe_q.width_src)) begin
      dmem_be_o    = 4'b0001 << offset;
      dmem_wdata_o = {4{pipe_q.write_data[7:0]}};
    end else if (is_half(pipe_q.width_src)) begin
      dmem_be_o    = 4'b0011 << offset;
      dmem_wdata_o = {2{pipe_q.write_data[15:0]}};
    end
  end

  // A granted-but-unanswered request cannot be cancelled on the bus, so a
  // flush at that point has to soak up the response in DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_REQ: begin
        if (misaligned) begin
          state_nxt = flush_m_i ? ST_IDLE : ST_DONE;
        end else if (issue) begin
          if (flush_m_i) begin
            state_nxt = (dmem_gnt_i & ~dmem_rvalid_i) ? ST_DRAIN : ST_IDLE;
          end else if (dmem_gnt_i) begin
            state_nxt = dmem_rvalid_i ? ST_DONE : ST_WAIT;
          end else begin
            state_nxt = ST_REQ;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_nxt = flush_m_i ? ST_IDLE : ST_DONE;
        end else if (flush_m_i) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush_m_i || advance) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (dmem_rvalid_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  load_extend u_load_extend (
    .width_src (pipe_q.width_src),
    .offset    (offset),
    .rdata     (dmem_rdata_i),
    .data      (ext_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_q <= '0;
    end else if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
      load_q <= misaligned ? 32'h0 : ext_data;
    end
  end

  always_comb begin
    case (pipe_q.result_src)
      RES_PCT: forward_data_m_o = pipe_q.pc_target;
      RES_PC4: forward_data_m_o = pipe_q.pc_plus4;
      RES_IMM: forward_data_m_o = pipe_q.imm_ext;
      RES_CSR: forward_data_m_o = pipe_q.csr_result;
      default: forward_data_m_o = pipe_q.alu_result;
    endcase
  end

  assign misaligned_m_o = misaligned;
  assign load_data_m_o  = load_q;
  assign valid_m_o      = pipe_q.valid;
  assign instr_m_o      = pipe_q.instr;
  assign alu_result_m_o = pipe_q.alu_result;
  assign pc_target_m_o  = pipe_q.pc_target;
  assign pc_plus4_m_o   = pipe_q.pc_plus4;
  assign imm_ext_m_o    = pipe_q.imm_ext;
  assign csr_result_m_o = pipe_q.csr_result;
  assign csr_addr_m_o   = pipe_q.csr_addr;
  assign rd_m_o         = pipe_q.rd;
  assign result_src_m_o = pipe_q.result_src;
  assign reg_write_m_o  = pipe_q.reg_write;
  assign csr_we_m_o     = pipe_q.csr_we;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ----------------------------------------------------------------------------
// tb_memory_stage : directed checks of memory_stage (stores, loads, flush, fwd)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_memory_stage;
  import memory_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_e_i;
  logic [31:0] instr_e_i, alu_result_e_i, write_data_e_i, pc_target_e_i;
  logic [31:0] pc_plus4_e_i, imm_ext_e_i, csr_result_e_i;
  logic [11:0] csr_addr_e_i;
  logic [4:0]  rd_e_i;
  logic [2:0]  width_src_e_i, result_src_e_i;
  logic        mem_write_e_i, reg_write_e_i, csr_we_e_i;
  logic        stall_m_i, flush_m_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        mem_stall_o, misaligned_m_o;
  logic [31:0] forward_data_m_o, load_data_m_o;
  logic        valid_m_o;
  logic [31:0] instr_m_o, alu_result_m_o, pc_target_m_o, pc_plus4_m_o;
  logic [31:0] imm_ext_m_o, csr_result_m_o;
  logic [11:0] csr_addr_m_o;
  logic [4:0]  rd_m_o;
  logic [2:0]  result_src_m_o;
  logic        reg_write_m_o, csr_we_m_o;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  memory_stage #(
    .ADDR_WIDTH     (32),
    .RESET_PC_PLUS4 (32'h0000_0100)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .valid_e_i        (valid_e_i),
    .instr_e_i        (instr_e_i),
    .alu_result_e_i   (alu_result_e_i),
    .write_data_e_i   (write_data_e_i),
    .pc_target_e_i    (pc_target_e_i),
    .pc_plus4_e_i     (pc_plus4_e_i),
    .imm_ext_e_i      (imm_ext_e_i),
    .csr_result_e_i   (csr_result_e_i),
    .csr_addr_e_i     (csr_addr_e_i),
    .rd_e_i           (rd_e_i),
    .width_src_e_i    (width_src_e_i),
    .result_src_e_i   (result_src_e_i),
    .mem_write_e_i    (mem_write_e_i),
    .reg_write_e_i    (reg_write_e_i),
    .csr_we_e_i       (csr_we_e_i),
    .stall_m_i        (stall_m_i),
    .flush_m_i        (flush_m_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_gnt_i       (dmem_gnt_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .mem_stall_o      (mem_stall_o),
    .misaligned_m_o   (misaligned_m_o),
    .forward_data_m_o (forward_data_m_o),
    .load_data_m_o    (load_data_m_o),
    .valid_m_o        (valid_m_o),
    .instr_m_o        (instr_m_o),
    .alu_result_m_o   (alu_result_m_o),
    .pc_target_m_o    (pc_target_m_o),
    .pc_plus4_m_o     (pc_plus4_m_o),
    .imm_ext_m_o      (imm_ext_m_o),
    .csr_result_m_o   (csr_result_m_o),
    .csr_addr_m_o     (csr_addr_m_o),
    .rd_m_o           (rd_m_o),
    .result_src_m_o   (result_src_m_o),
    .reg_write_m_o    (reg_write_m_o),
    .csr_we_m_o       (csr_we_m_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_e(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [2:0] w, input logic [2:0] rs, input logic mw);
    valid_e_i      = v;
    alu_result_e_i = alu;
    write_data_e_i = wd;
    width_src_e_i  = w;
    result_src_e_i = rs;
    mem_write_e_i  = mw;
    reg_write_e_i  = v & ~mw;
  endtask

  logic [2:0]  fwd_src [5] = '{RES_PC4, RES_PCT, RES_IMM, RES_CSR, RES_ALU};
  logic [31:0] fwd_exp [5] = '{32'h44, 32'h88, 32'hCC, 32'hDD, 32'h11};

  initial begin
    reset_i = 1'b1;
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    instr_e_i = 32'h0; pc_target_e_i = 32'h0; pc_plus4_e_i = 32'h0;
    imm_ext_e_i = 32'h0; csr_result_e_i = 32'h0; csr_addr_e_i = 12'h0;
    rd_e_i = 5'd0; csr_we_e_i = 1'b0; stall_m_i = 1'b0; flush_m_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    chk("rst_valid", {31'h0, valid_m_o}, 32'h0);
    chk("rst_pc4", pc_plus4_m_o, 32'h100);
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, mem_stall_o}, 32'h0);
    chk("rst_load", load_data_m_o, 32'h0);

    // Store byte 0xAB at 0x1003, gnt+rvalid together
    set_e(1'b1, 32'h1003, 32'h0000_00AB, WIDTH_BU, RES_ALU, 1'b1);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    #1;
    chk("sb_req", {31'h0, dmem_req_o}, 32'h1);
    chk("sb_we", {31'h0, dmem_we_o}, 32'h1);
    chk("sb_addr", dmem_addr_o, 32'h1000);
    chk("sb_be", {28'h0, dmem_be_o}, 32'h8);
    chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    chk("sb_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    chk("sb_done_stall", {31'h0, mem_stall_o}, 32'h0);
    chk("sb_done_req", {31'h0, dmem_req_o}, 32'h0);
    chk("sb_done_valid", {31'h0, valid_m_o}, 32'h1);
    tick();
    chk("sb_adv_valid", {31'h0, valid_m_o}, 32'h0);

    // Load half signed 0x2002: gnt at cycle 2, rvalid at cycle 4
    set_e(1'b1, 32'h2002, 32'h0, WIDTH_HS, RES_MEM, 1'b0);
    rd_e_i = 5'd5;
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    #1;
    chk("lh_c0_req", {31'h0, dmem_req_o}, 32'h1);
    chk("lh_c0_we", {31'h0, dmem_we_o}, 32'h0);
    chk("lh_c0_be", {28'h0, dmem_be_o}, 32'hC);
    chk("lh_c0_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    chk("lh_c1_req", {31'h0, dmem_req_o}, 32'h1);
    chk("lh_c1_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    dmem_gnt_i = 1'b1;
    #1;
    chk("lh_c2_req", {31'h0, dmem_req_o}, 32'h1);
    chk("lh_c2_addr", dmem_addr_o, 32'h2000);
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    chk("lh_c3_req", {31'h0, dmem_req_o}, 32'h0);
    chk("lh_c3_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_1234;
    #1;
    chk("lh_c4_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("lh_done_stall", {31'h0, mem_stall_o}, 32'h0);
    chk("lh_data", load_data_m_o, 32'hFFFF_8001);
    chk("lh_fwd", forward_data_m_o, 32'h2002);
    chk("lh_rd", {27'h0, rd_m_o}, 32'h5);
    tick();

    // Load byte unsigned offset 1, then hold the register for 3 cycles
    set_e(1'b1, 32'h3001, 32'h0, WIDTH_BU, RES_MEM, 1'b0);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_FF00;
    stall_m_i = 1'b1;
    #1;
    chk("lbu_req", {31'h0, dmem_req_o}, 32'h1);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h1234_5678;
    repeat (3) begin
      #1;
      chk("lbu_hold_req", {31'h0, dmem_req_o}, 32'h0);
      chk("lbu_hold_data", load_data_m_o, 32'h0000_00FF);
      chk("lbu_hold_valid", {31'h0, valid_m_o}, 32'h1);
      tick();
    end
    stall_m_i = 1'b0;
    #1;
    chk("lbu_rel_req", {31'h0, dmem_req_o}, 32'h0);
    tick();
    chk("lbu_adv_valid", {31'h0, valid_m_o}, 32'h0);

    // Flush while waiting for a load response; next store waits for the drain
    set_e(1'b1, 32'h4000, 32'h0, WIDTH_W, RES_MEM, 1'b0);
    tick();
    set_e(1'b1, 32'h5000, 32'h1234_5678, WIDTH_W, RES_ALU, 1'b1);
    dmem_gnt_i = 1'b1;
    #1;
    chk("fl_req", {31'h0, dmem_req_o}, 32'h1);
    tick();
    dmem_gnt_i = 1'b0; flush_m_i = 1'b1;
    #1;
    chk("fl_wait_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    flush_m_i = 1'b0;
    #1;
    chk("fl_drain_valid", {31'h0, valid_m_o}, 32'h0);
    chk("fl_drain_stall", {31'h0, mem_stall_o}, 32'h1);
    chk("fl_drain_req", {31'h0, dmem_req_o}, 32'h0);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("fl_drain2_stall", {31'h0, mem_stall_o}, 32'h1);
    chk("fl_drain2_req", {31'h0, dmem_req_o}, 32'h0);
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("fl_idle_stall", {31'h0, mem_stall_o}, 32'h0);
    chk("fl_idle_req", {31'h0, dmem_req_o}, 32'h0);
    chk("fl_idle_valid", {31'h0, valid_m_o}, 32'h0);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    #1;
    chk("fl_next_req", {31'h0, dmem_req_o}, 32'h1);
    chk("fl_next_addr", dmem_addr_o, 32'h5000);
    chk("fl_next_be", {28'h0, dmem_be_o}, 32'hF);
    chk("fl_next_wdata", dmem_wdata_o, 32'h1234_5678);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    tick();

    // Forwarding sources, no memory traffic
    pc_plus4_e_i = 32'h44; pc_target_e_i = 32'h88; imm_ext_e_i = 32'hCC;
    csr_result_e_i = 32'hDD; csr_addr_e_i = 12'h305;
    for (int i = 0; i < 5; i++) begin
      set_e(1'b1, 32'h11, 32'h0, WIDTH_W, fwd_src[i], 1'b0);
      tick();
      chk("fwd_data", forward_data_m_o, fwd_exp[i]);
      chk("fwd_req", {31'h0, dmem_req_o}, 32'h0);
      chk("fwd_stall", {31'h0, mem_stall_o}, 32'h0);
    end
    chk("fwd_pc4", pc_plus4_m_o, 32'h44);
    chk("fwd_csr_addr", {20'h0, csr_addr_m_o}, 32'h305);
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    tick();

    // Store half at offset 2
    set_e(1'b1, 32'h7002, 32'h0000_BEEF, WIDTH_HU, RES_ALU, 1'b1);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    #1;
    chk("sh_be", {28'h0, dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    chk("sh_addr", dmem_addr_o, 32'h7000);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    tick();

    // Load byte signed offset 0
    set_e(1'b1, 32'h7100, 32'h0, WIDTH_BS, RES_MEM, 1'b0);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_0080;
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    chk("lb_data", load_data_m_o, 32'hFFFF_FF80);
    tick();

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load: no request, one stall cycle, zero data
    set_e(1'b1, 32'h3002, 32'h0, WIDTH_W, RES_MEM, 1'b0);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    #1;
    chk("mis_flag", {31'h0, misaligned_m_o}, 32'h1);
    chk("mis_req", {31'h0, dmem_req_o}, 32'h0);
    chk("mis_stall", {31'h0, mem_stall_o}, 32'h1);
    tick();
    chk("mis_done_stall", {31'h0, mem_stall_o}, 32'h0);
    chk("mis_done_req", {31'h0, dmem_req_o}, 32'h0);
    chk("mis_done_data", load_data_m_o, 32'h0);
    tick();
`else
    // Half at offset 3 is truncated to byte lane 3
    set_e(1'b1, 32'h6003, 32'h0, WIDTH_HS, RES_MEM, 1'b0);
    tick();
    set_e(1'b0, 32'h0, 32'h0, WIDTH_W, RES_ALU, 1'b0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hF000_0000;
    #1;
    chk("h3_flag", {31'h0, misaligned_m_o}, 32'h0);
    chk("h3_req", {31'h0, dmem_req_o}, 32'h1);
    chk("h3_be", {28'h0, dmem_be_o}, 32'h8);
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    chk("h3_data", load_data_m_o, 32'h0000_00F0);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
